alu4_seq: RTL and testbench
===========================

ALU4_SEQ -- requirements
Module: alu4_seq

Interface
REQ-001 The block SHALL have the parameter NREGS, default 4, meaning the number of 4-bit general registers; it is fixed at 4, and the 2-bit register fields depend on it.
REQ-002 The port list SHALL be as follows; the clock is single, and reset is asynchronous and active-high:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- instr_valid  input  1  instruction offered
- instr_ready  output  1  block can accept instruction
- instr  input  10  [9:6] op, [5:4] rd, [3:2] ra, [1:0] rb
- alu_a  output  4  operand A to the 4-bit ALU stage
- alu_b  output  4  operand B to the 4-bit ALU stage
- alu_op  output  4  opcode to the 4-bit ALU stage
- alu_y  input  4  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_flags  input  4  ALU flags {cf, zf, pf, sf}
- res_valid  output  1  one-cycle result strobe
- res_data  output  4  result written to rd
- res_rd  output  2  destination register index
- res_flags  output  4  flag register after this instruction
- dbg_sel  input  2  debug register select
- dbg_data  output  4  R[dbg_sel], combinational

Function
REQ-003 The FSM SHALL have three states:
- IDLE: instr_ready=1.
- EXEC: instr_ready=0.
- WB: instr_ready=1, res_valid=1.
REQ-004 A handshake SHALL occur when instr_valid&&instr_ready at a rising edge; the instruction is latched and the state goes to EXEC.
REQ-005 The FSM SHALL make the following transitions:
- IDLE -> EXEC on handshake; otherwise stay in IDLE.
- EXEC -> WB unconditionally.
- WB -> EXEC on handshake; otherwise WB -> IDLE.
REQ-006 In EXEC, the ALU outputs SHALL be driven from registered values only: alu_a=R[ra], alu_b=R[rb], alu_op=op.
REQ-007 In IDLE and WB, alu_a, alu_b and alu_op SHALL all be 0.
REQ-008 For op 0..14, the edge ending EXEC SHALL write alu_y to R[rd] and alu_flags to the flag register, and SHALL load res_data=alu_y and res_rd=rd.
REQ-009 op 15 SHALL be LDI: R[rd]={ra,rb} (4-bit immediate), the flag register is unchanged, and the ALU is still driven with op 15 but alu_y/alu_flags are ignored.
REQ-010 res_flags SHALL always equal the flag register.
REQ-011 res_data, res_rd and res_flags SHALL hold their value until the next WB update.
REQ-012 Latency SHALL be fixed: a handshake at edge N gives res_valid high in the cycle after edge N+1, and R[rd] is readable on dbg_data in that same cycle.
REQ-013 Sustained throughput SHALL be one instruction per 2 cycles (EXEC/WB alternating).
REQ-014 An instruction reading the rd of the immediately preceding instruction SHALL see the updated value; no hazard logic is needed because the write precedes the next EXEC.
REQ-015 The register file SHALL be written only at the EXEC->WB edge, and dbg_sel SHALL have no side effects.
REQ-016 instr SHALL be ignored when instr_ready=0, and instr_valid may drop at any time without effect.

Reset
REQ-017 On rst high, and asynchronously mid-instruction, the following SHALL be forced; an in-flight instruction is discarded with no writeback:
- state=IDLE
- R[0..3]=0
- flag register=0
- res_valid=0, res_data=0, res_rd=0
- alu_a=0, alu_b=0, alu_op=0
REQ-018 instr_ready SHALL be 1 from the first cycle after rst deasserts.

Structure
REQ-019 The shared package alu4_seq_pkg SHALL hold:
- the state enum (IDLE/EXEC/WB)
- the opcode constants 0..15, including OP_LDI=15
- the instr field bit positions
- the flag bit indices CF=3, ZF=2, PF=1, SF=0
REQ-020 The register file SHALL be one sub-module, alu4_seq_regfile: 4x4 bits, two combinational read ports plus the debug port, one synchronous write port, asynchronous reset.

Verification
REQ-021 LDI R1=4'hF, then op1 (A+1) rd=R2 ra=R1 SHALL give res_data=0, res_rd=2, res_flags=4'b1110, and dbg_data(sel=2)=0.
REQ-022 LDI R0=3, LDI R3=5, then op3 (A+B+1) rd=R1 ra=R0 rb=R3 SHALL give res_data=9 and res_flags=4'b0010; during EXEC alu_a=3, alu_b=5, alu_op=3.
REQ-023 With instr_valid held high for 4 instructions, handshakes SHALL occur every 2 cycles, res_valid SHALL pulse in each WB, and instr_ready SHALL be low in each EXEC.
REQ-024 A chained dependency, R1=R1+1 issued three times from R1=4'hE, SHALL give results 4'hF, 4'h0 (cf=1, zf=1), 4'h1.
REQ-025 rst asserted during EXEC of a write to R2 SHALL leave R2=0, with no res_valid pulse and instr_ready=1 after release.
REQ-026 An LDI after a flag-setting op SHALL leave res_flags equal to the prior flags.

Source files
------------

// File: rtl/alu4_seq_pkg.sv
// Shared types and constants for the sequenced 4-bit ALU front end:
// FSM states, opcodes, instruction field layout and flag bit indices.
package alu4_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StWb
  } state_e;

  typedef enum logic [3:0] {
    OpAlu0,
    OpAlu1,
    OpAlu2,
    OpAlu3,
    OpAlu4,
    OpAlu5,
    OpAlu6,
    OpAlu7,
    OpAlu8,
    OpAlu9,
    OpAlu10,
    OpAlu11,
    OpAlu12,
    OpAlu13,
    OpAlu14,
    OpLdi
  } op_e;

  localparam logic [3:0] OP_LDI = 4'd15;

  localparam int unsigned OpMsb = 9;
  localparam int unsigned OpLsb = 6;
  localparam int unsigned RdMsb = 5;
  localparam int unsigned RdLsb = 4;
  localparam int unsigned RaMsb = 3;
  localparam int unsigned RaLsb = 2;
  localparam int unsigned RbMsb = 1;
  localparam int unsigned RbLsb = 0;

  localparam int unsigned FlagCf = 3;
  localparam int unsigned FlagZf = 2;
  localparam int unsigned FlagPf = 1;
  localparam int unsigned FlagSf = 0;

  typedef struct packed {
    op_e        op;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [1:0] rb;
  } instr_t;

endpackage

// File: rtl/alu4_seq_regfile.sv
// 4-bit register file: two combinational read ports, a debug read port and
// one synchronous write port, all cleared by asynchronous reset.
module alu4_seq_regfile #(
  parameter int unsigned NumRegs = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       we_i,
  input  logic [1:0] waddr_i,
  input  logic [3:0] wdata_i,
  input  logic [1:0] raddr_a_i,
  output logic [3:0] rdata_a_o,
  input  logic [1:0] raddr_b_i,
  output logic [3:0] rdata_b_o,
  input  logic [1:0] dbg_sel_i,
  output logic [3:0] dbg_data_o
);

  logic [3:0] regs_q [NumRegs];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= 4'h0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = regs_q[raddr_a_i];
  assign rdata_b_o  = regs_q[raddr_b_i];
  assign dbg_data_o = regs_q[dbg_sel_i];

endmodule

// File: rtl/alu4_seq.sv
// Two-phase instruction sequencer around an external 4-bit ALU: latch an
// instruction, drive the ALU for one cycle, then write back and strobe the result.
module alu4_seq
  import alu4_seq_pkg::*;
#(
  parameter int unsigned NREGS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [9:0] instr,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [3:0] alu_y,
  input  logic [3:0] alu_flags,
  output logic       res_valid,
  output logic [3:0] res_data,
  output logic [1:0] res_rd,
  output logic [3:0] res_flags,
  input  logic [1:0] dbg_sel,
  output logic [3:0] dbg_data
);

  state_e     state_q, state_d;
  instr_t     instr_q;
  logic [3:0] flags_q;
  logic [3:0] res_data_q;
  logic [1:0] res_rd_q;
  logic       handshake;
  logic       is_ldi;
  logic       wr_en;
  logic [3:0] wr_data;
  logic [3:0] rdata_a, rdata_b;

  assign handshake = instr_valid & instr_ready;
  assign is_ldi    = (instr_q.op == OpLdi);
  assign wr_en     = (state_q == StExec);
  // LDI takes its immediate from the ra/rb fields and bypasses the ALU result.
  assign wr_data   = is_ldi ? {instr_q.ra, instr_q.rb} : alu_y;

  alu4_seq_regfile #(
    .NumRegs(NREGS)
  ) u_regfile (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (wr_en),
    .waddr_i   (instr_q.rd),
    .wdata_i   (wr_data),
    .raddr_a_i (instr_q.ra),
    .rdata_a_o (rdata_a),
    .raddr_b_i (instr_q.rb),
    .rdata_b_o (rdata_b),
    .dbg_sel_i (dbg_sel),
    .dbg_data_o(dbg_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = handshake ? StExec : StIdle;
      StExec:  state_d = StWb;
      StWb:    state_d = handshake ? StExec : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    instr_ready = (state_q != StExec);
    res_valid   = (state_q == StWb);
    alu_a       = 4'h0;
    alu_b       = 4'h0;
    alu_op      = 4'h0;
    if (state_q == StExec) begin
      alu_a  = rdata_a;
      alu_b  = rdata_b;
      alu_op = instr_q.op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= '0;
      flags_q    <= 4'h0;
      res_data_q <= 4'h0;
      res_rd_q   <= 2'd0;
    end else begin
      if (handshake) begin
        instr_q.op <= op_e'(instr[OpMsb:OpLsb]);
        instr_q.rd <= instr[RdMsb:RdLsb];
        instr_q.ra <= instr[RaMsb:RaLsb];
        instr_q.rb <= instr[RbMsb:RbLsb];
      end
      if (wr_en) begin
        res_data_q <= wr_data;
        res_rd_q   <= instr_q.rd;
        if (!is_ldi) begin
          flags_q <= alu_flags;
        end
      end
    end
  end

  assign res_data  = res_data_q;
  assign res_rd    = res_rd_q;
  assign res_flags = flags_q;

endmodule

// File: tb/tb_alu4_seq.sv
// Directed bench for alu4_seq; plays the external ALU with a small adder model
// whose op 15 output is deliberately junk so LDI must ignore it.
module tb_alu4_seq;
  import alu4_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [9:0] instr = '0;
  logic [3:0] alu_a, alu_b, alu_op, alu_y, alu_flags;
  logic       res_valid;
  logic [3:0] res_data, res_flags, dbg_data;
  logic [1:0] res_rd;
  logic [1:0] dbg_sel = 2'd0;

  int passed = 0;
  int total  = 0;

  logic [3:0] ex_a, ex_b, ex_op, wb_data, wb_flags;
  logic [1:0] wb_rd;
  logic       wb_valid;

  alu4_seq #(
    .NREGS(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_y      (alu_y),
    .alu_flags  (alu_flags),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_rd     (res_rd),
    .res_flags  (res_flags),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  // ALU model: op0 A+B, op1 A+1, op2 A-B, op3 A+B+1; sf is the sign of the exact result.
  logic [3:0] m_b;
  logic       m_cin;
  logic [4:0] m_u, m_s;
  always_comb begin
    m_b   = alu_b;
    m_cin = 1'b0;
    case (alu_op)
      4'd1:    begin m_b = 4'h0; m_cin = 1'b1; end
      4'd2:    begin m_b = ~alu_b; m_cin = 1'b1; end
      4'd3:    m_cin = 1'b1;
      default: ;
    endcase
    m_u = {1'b0, alu_a} + {1'b0, m_b} + {4'b0, m_cin};
    m_s = {alu_a[3], alu_a} + {m_b[3], m_b} + {4'b0, m_cin};
    alu_y = m_u[3:0];
    alu_flags = 4'h0;
    alu_flags[FlagCf] = m_u[4];
    alu_flags[FlagZf] = (m_u[3:0] == 4'h0);
    alu_flags[FlagPf] = ~^m_u[3:0];
    alu_flags[FlagSf] = m_s[4];
    if (alu_op == OP_LDI) begin
      alu_y     = 4'hA;
      alu_flags = 4'hF;
    end
  end

  // Called at a falling edge; returns at the falling edge inside WB.
  task automatic run_instr(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                           input logic [1:0] rb);
    instr_valid = 1'b1;
    instr = {op, rd, ra, rb};
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    ex_a  = alu_a;
    ex_b  = alu_b;
    ex_op = alu_op;
    @(negedge clk);
    wb_valid = res_valid;
    wb_data  = res_data;
    wb_rd    = res_rd;
    wb_flags = res_flags;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (instr_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", instr_ready);
    else passed++;
    total++;
    if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b expected 0", res_valid);
    else passed++;
    total++;
    if ({res_data, res_rd, res_flags} !== 10'h0)
      $display("FAIL reset_res: got %h/%h/%h expected 0/0/0", res_data, res_rd, res_flags);
    else passed++;
    total++;
    if ({alu_a, alu_b, alu_op} !== 12'h0)
      $display("FAIL reset_alu: got %h/%h/%h expected 0/0/0", alu_a, alu_b, alu_op);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      total++;
      if (dbg_data !== 4'h0) $display("FAIL reset_reg%0d: got %h expected 0", i, dbg_data);
      else passed++;
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (instr_ready !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", instr_ready);
    else passed++;
  endtask

  task automatic test_ldi_inc();
    run_instr(4'd15, 2'd1, 2'd3, 2'd3);
    total++;
    if ({wb_valid, wb_data, wb_rd, wb_flags} !== {1'b1, 4'hF, 2'd1, 4'h0})
      $display("FAIL ldi_r1: got v=%b d=%h rd=%0d f=%b expected v=1 d=f rd=1 f=0000",
               wb_valid, wb_data, wb_rd, wb_flags);
    else passed++;
    run_instr(4'd1, 2'd2, 2'd1, 2'd0);
    total++;
    if ({ex_a, ex_op} !== {4'hF, 4'd1})
      $display("FAIL inc_exec_alu: got a=%h op=%h expected a=f op=1", ex_a, ex_op);
    else passed++;
    total++;
    if ({wb_valid, wb_data, wb_rd, wb_flags} !== {1'b1, 4'h0, 2'd2, 4'b1110})
      $display("FAIL inc_wrap: got v=%b d=%h rd=%0d f=%b expected v=1 d=0 rd=2 f=1110",
               wb_valid, wb_data, wb_rd, wb_flags);
    else passed++;
    dbg_sel = 2'd2;
    #1;
    total++;
    if (dbg_data !== 4'h0) $display("FAIL inc_dbg_r2: got %h expected 0", dbg_data);
    else passed++;
  endtask

  task automatic test_add_carry();
    run_instr(4'd15, 2'd0, 2'd0, 2'd3);
    run_instr(4'd15, 2'd3, 2'd1, 2'd1);
    run_instr(4'd3, 2'd1, 2'd0, 2'd3);
    total++;
    if ({ex_a, ex_b, ex_op} !== {4'd3, 4'd5, 4'd3})
      $display("FAIL adc_exec_alu: got a=%h b=%h op=%h expected a=3 b=5 op=3", ex_a, ex_b, ex_op);
    else passed++;
    total++;
    if ({wb_data, wb_rd, wb_flags} !== {4'h9, 2'd1, 4'b0010})
      $display("FAIL adc_result: got d=%h rd=%0d f=%b expected d=9 rd=1 f=0010",
               wb_data, wb_rd, wb_flags);
    else passed++;
    dbg_sel = 2'd1;
    #1;
    total++;
    if (dbg_data !== 4'h9) $display("FAIL adc_dbg_r1: got %h expected 9", dbg_data);
    else passed++;
  endtask

  task automatic test_ldi_flags();
    run_instr(4'd15, 2'd2, 2'd1, 2'd3);
    total++;
    if (ex_op !== 4'd15) $display("FAIL ldi_exec_op: got %h expected f", ex_op);
    else passed++;
    total++;
    if ({wb_data, wb_rd, wb_flags} !== {4'h7, 2'd2, 4'b0010})
      $display("FAIL ldi_keeps_flags: got d=%h rd=%0d f=%b expected d=7 rd=2 f=0010",
               wb_data, wb_rd, wb_flags);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_seq [4];
    logic       exp_ready, exp_rv;
    exp_seq[0] = 4'hF;
    exp_seq[1] = 4'h0;
    exp_seq[2] = 4'h1;
    exp_seq[3] = 4'h2;
    run_instr(4'd15, 2'd1, 2'd3, 2'd2);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = {4'd1, 2'd1, 2'd1, 2'd0};
    for (int k = 0; k < 8; k++) begin
      exp_ready = (k % 2 == 0);
      exp_rv    = (k % 2 == 0) && (k > 0);
      total++;
      if ({instr_ready, res_valid} !== {exp_ready, exp_rv})
        $display("FAIL b2b_cycle%0d: got ready=%b rv=%b expected ready=%b rv=%b",
                 k, instr_ready, res_valid, exp_ready, exp_rv);
      else passed++;
      if (exp_rv) begin
        total++;
        if (res_data !== exp_seq[k/2-1])
          $display("FAIL chain_result%0d: got %h expected %h", k/2-1, res_data, exp_seq[k/2-1]);
        else passed++;
      end
      if (k == 7) instr_valid = 1'b0;
      @(negedge clk);
      if (k == 1) begin
        total++;
        if (res_flags !== 4'b0011) $display("FAIL chain_flags0: got %b expected 0011", res_flags);
        else passed++;
      end
      if (k == 3) begin
        total++;
        if (res_flags !== 4'b1110) $display("FAIL chain_flags1: got %b expected 1110", res_flags);
        else passed++;
      end
    end
    total++;
    if ({res_valid, res_data} !== {1'b1, exp_seq[3]})
      $display("FAIL b2b_last: got rv=%b d=%h expected rv=1 d=2", res_valid, res_data);
    else passed++;
    @(negedge clk);
    total++;
    if ({res_valid, instr_ready, res_data} !== {1'b0, 1'b1, 4'h2})
      $display("FAIL idle_hold: got rv=%b ready=%b d=%h expected rv=0 ready=1 d=2",
               res_valid, instr_ready, res_data);
    else passed++;
  endtask

  task automatic test_reset_mid();
    run_instr(4'd15, 2'd2, 2'd1, 2'd2);
    dbg_sel = 2'd2;
    #1;
    total++;
    if (dbg_data !== 4'h6) $display("FAIL pre_reset_r2: got %h expected 6", dbg_data);
    else passed++;
    @(negedge clk);
    instr_valid = 1'b1;
    instr = {4'd3, 2'd2, 2'd2, 2'd2};
    @(posedge clk);
    #1 instr_valid = 1'b0;
    total++;
    if ({alu_a, alu_op} !== {4'h6, 4'd3})
      $display("FAIL mid_exec_alu: got a=%h op=%h expected a=6 op=3", alu_a, alu_op);
    else passed++;
    #1 rst = 1'b1;
    #1;
    total++;
    if ({alu_a, alu_b, alu_op, res_valid, instr_ready} !== {12'h0, 1'b0, 1'b1})
      $display("FAIL mid_reset_outputs: got a=%h b=%h op=%h rv=%b ready=%b expected 0/0/0/0/1",
               alu_a, alu_b, alu_op, res_valid, instr_ready);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({res_valid, instr_ready, dbg_data, res_data} !== {1'b0, 1'b1, 4'h0, 4'h0})
        $display("FAIL post_reset%0d: got rv=%b ready=%b r2=%h d=%h expected 0/1/0/0",
                 k, res_valid, instr_ready, dbg_data, res_data);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_ldi_inc();
    test_add_carry();
    test_ldi_flags();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
